// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand-fetch stage with busy scoreboard; OPFETCH_FORWARD_EN enables wb->operand bypass
module operand_fetch #(
    parameter int WB_PORTS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [4:0]             in_rd,
    input  logic                   in_wen,
    input  logic [63:0]            in_pc,
    output logic [4:0]             rf_ra1,
    output logic [4:0]             rf_ra2,
    input  logic [63:0]            rf_rd1,
    input  logic [63:0]            rf_rd2,
    input  logic [WB_PORTS-1:0]    wb_valid,
    input  logic [5*WB_PORTS-1:0]  wb_addr,
    input  logic [64*WB_PORTS-1:0] wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_pc,
    output logic [4:0]             out_rd,
    output logic                   out_wen,
    output logic [63:0]            out_op1,
    output logic [63:0]            out_op2
);

    logic [31:0] busy;
    logic [31:0] busy_next;
    logic        fwd1;
    logic        fwd2;
    logic [63:0] op1_res;
    logic [63:0] op2_res;
    logic        raw1;
    logic        raw2;
    logic        waw;
    logic        hazard;
    logic        slot_free;
    logic        issue;

    assign rf_ra1 = in_rs1;
    assign rf_ra2 = in_rs2;

`ifdef OPFETCH_FORWARD_EN
    // Later ports overwrite earlier matches, so the highest port index wins.
    always_comb begin
        fwd1    = 1'b0;
        fwd2    = 1'b0;
        op1_res = rf_rd1;
        op2_res = rf_rd2;
        for (int j = 0; j < WB_PORTS; j++) begin
            if (wb_valid[j] && wb_addr[5*j +: 5] == in_rs1 && in_rs1 != 5'd0) begin
                fwd1    = 1'b1;
                op1_res = wb_data[64*j +: 64];
            end
            if (wb_valid[j] && wb_addr[5*j +: 5] == in_rs2 && in_rs2 != 5'd0) begin
                fwd2    = 1'b1;
                op2_res = wb_data[64*j +: 64];
            end
        end
    end
`else
    logic unused_wb_data;

    assign fwd1           = 1'b0;
    assign fwd2           = 1'b0;
    assign op1_res        = rf_rd1;
    assign op2_res        = rf_rd2;
    assign unused_wb_data = ^wb_data;
`endif

    assign raw1      = busy[in_rs1] & ~fwd1;
    assign raw2      = busy[in_rs2] & ~fwd2;
    assign waw       = in_wen & (in_rd != 5'd0) & busy[in_rd];
    assign hazard    = raw1 | raw2 | waw;
    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = ~hazard & slot_free;
    assign issue     = in_valid & in_ready;

    // Clears are applied first so a same-edge issue to the same index wins.
    always_comb begin
        busy_next = busy;
        for (int j = 0; j < WB_PORTS; j++) begin
            if (wb_valid[j]) begin
                busy_next[wb_addr[5*j +: 5]] = 1'b0;
            end
        end
        if (issue && in_wen) begin
            busy_next[in_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy      <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
        end else begin
            busy <= busy_next;
            if (issue) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                out_rd    <= in_rd;
                out_wen   <= in_wen;
                out_op1   <= op1_res;
                out_op2   <= op2_res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
